// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the
// instruction memory (slave).
`timescale 1ns/1ps
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        Ihit;

    modport master (output imem_req, output imem_addr, input imem_rdata, input Ihit);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output Ihit);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word requests, presents one instruction at a
// time to decode, buffers it under back-pressure and absorbs redirects.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 Dhit,
    input  logic                 redirect,
    input  logic [31:0]          redirect_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          PCOut,
    output logic [31:0]          PCPlus4Out,
    output logic [31:0]          instrOut,
    output logic                 BranchOut,
    output logic                 validOut
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_buf, w_buf_next;
    logic        r_pend_valid, w_pend_valid_next;
    logic [31:0] r_pend_target, w_pend_target_next;

    logic        w_req;
    logic        w_valid;
    logic        w_advance;
    logic [31:0] w_instr;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;

    assign w_target   = redirect_target & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_advance  = w_valid & en & Dhit & ~redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_buf         <= 32'h0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_buf         <= w_buf_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_buf_next         = r_buf;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        w_req              = 1'b0;
        w_valid            = 1'b0;
        w_instr            = 32'h0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                if (redirect) begin
                    w_pc_next = w_target;
                end
            end
            S_REQ, S_WAIT: begin
                w_req = 1'b1;
                if (!imem.Ihit) begin
                    // Request still in flight: remember the newest redirect for later.
                    w_state_next = S_WAIT;
                    if (redirect) begin
                        w_pend_valid_next  = 1'b1;
                        w_pend_target_next = w_target;
                    end
                end else if (r_pend_valid || redirect) begin
                    // Returned word belongs to the abandoned path; a same-cycle redirect is newest.
                    w_state_next      = S_REQ;
                    w_pend_valid_next = 1'b0;
                    w_pc_next         = redirect ? w_target : r_pend_target;
                end else begin
                    w_valid    = 1'b1;
                    w_instr    = imem.imem_rdata;
                    w_buf_next = imem.imem_rdata;
                    if (w_advance) begin
                        w_pc_next    = w_pc_plus4;
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = S_REQ;
                end else begin
                    w_valid = 1'b1;
                    w_instr = r_buf;
                    if (w_advance) begin
                        w_pc_next    = w_pc_plus4;
                        w_state_next = S_REQ;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Control transfers: REGIMM/J/JAL/BEQ/BNE/BLEZ/BGTZ, plus JR/JALR under SPECIAL.
    assign w_opcode = w_instr[31:26];
    assign w_funct  = w_instr[5:0];

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign PCOut          = r_pc;
    assign PCPlus4Out     = w_pc_plus4;
    assign instrOut       = w_instr;
    assign validOut       = w_valid;
    assign BranchOut      = w_valid &
                            (((w_opcode != 6'b000000) && (w_opcode[5:3] == 3'b000)) ||
                             ((w_opcode == 6'b000000) && (w_funct[5:1] == 5'b00100)));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        Dhit = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] PCOut, PCPlus4Out, instrOut;
    logic        BranchOut, validOut;

    int checks = 0;
    int errors = 0;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .en(en), .Dhit(Dhit), .redirect(redirect),
        .redirect_target(redirect_target), .imem(bus), .PCOut(PCOut),
        .PCPlus4Out(PCPlus4Out), .instrOut(instrOut), .BranchOut(BranchOut),
        .validOut(validOut)
    );

    always #5 clk = ~clk;

    // Model: has fetch begun, is an instruction parked for decode, outstanding redirect.
    bit          m_started, m_have, m_pend, have_last;
    logic [31:0] m_pc, m_instr, m_pend_tgt;
    logic        exp_req, exp_valid, exp_branch;
    logic [31:0] exp_addr, exp_instr, exp_pc;

    function automatic bit is_ctrl(input logic [31:0] w);
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    task automatic model_reset();
        m_started = 0; m_have = 0; m_pend = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_pend_tgt = 32'h0;
        have_last = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        t = {redirect_target[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1;
            if (redirect) m_pc = t;
        end else if (m_have) begin
            if (redirect) begin m_pc = t; m_have = 0; end
            else if (en && Dhit) begin m_pc = m_pc + 32'd4; m_have = 0; end
        end else if (!bus.Ihit) begin
            if (redirect) begin m_pend = 1; m_pend_tgt = t; end
        end else if (m_pend || redirect) begin
            m_pc = redirect ? t : m_pend_tgt;
            m_pend = 0;
        end else if (en && Dhit) begin
            m_pc = m_pc + 32'd4;
        end else begin
            m_have = 1; m_instr = bus.imem_rdata;
        end
    endtask

    task automatic predict();
        exp_req = 0; exp_valid = 0; exp_instr = 32'h0;
        exp_addr = m_pc; exp_pc = m_pc;
        if (m_started) begin
            if (m_have) begin
                if (!redirect) begin exp_valid = 1; exp_instr = m_instr; end
            end else begin
                exp_req = 1;
                if (bus.Ihit && !m_pend && !redirect) begin
                    exp_valid = 1; exp_instr = bus.imem_rdata;
                end
            end
        end
        exp_branch = exp_valid && is_ctrl(exp_instr);
    endtask

    // One cycle: retire the previous cycle into the model, drive at negedge, settle.
    task automatic apply(input logic a_en, input logic a_dhit, input logic a_redir,
                         input logic [31:0] a_tgt, input logic a_ihit, input logic [31:0] a_rdata);
        if (have_last) model_step();
        @(negedge clk);
        en = a_en; Dhit = a_dhit; redirect = a_redir; redirect_target = a_tgt;
        bus.Ihit = a_ihit; bus.imem_rdata = a_rdata;
        predict();
        have_last = 1;
        #1;
        $display("[%0t] en=%0b dhit=%0b redir=%0b ihit=%0b | req=%0b addr=%h valid=%0b pc=%h instr=%h br=%0b",
                 $time, en, Dhit, redirect, bus.Ihit, bus.imem_req, bus.imem_addr, validOut, PCOut, instrOut, BranchOut);
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        en = 0; Dhit = 1; redirect = 0; redirect_target = 32'h0;
        bus.Ihit = 0; bus.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #3 reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", bus.imem_req); end
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", validOut); end
        checks++; if (instrOut !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instrOut); end
        checks++; if (BranchOut !== 1'b0) begin errors++; $display("FAIL rst_branch: got %0b want 0", BranchOut); end
        checks++; if (PCOut !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", PCOut); end
        checks++; if (PCPlus4Out !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h want 4", PCPlus4Out); end
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL first_req_idle: got %0b want 0", bus.imem_req); end
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %0b want 1", bus.imem_req); end
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        words = '{32'h2001_0005, 32'h2002_000A, 32'h0022_1820, 32'hAC03_0000};
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            apply(1, 1, 0, 32'h0, 1, words[k]);
            checks++; if (bus.imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, bus.imem_addr, 4 * k); end
            checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", k, validOut); end
            checks++; if (instrOut !== words[k]) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instrOut, words[k]); end
        end
    endtask

    task automatic test_ihit_stall();
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h0);
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        apply(1, 1, 0, 32'h0, 1, 32'h2002_0006);
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 0, 32'h0, 0, 32'h0);
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got req=%0b addr=%h want req=1 addr=8", k, bus.imem_req, bus.imem_addr); end
            checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 0", k, validOut); end
        end
        apply(1, 1, 0, 32'h0, 1, 32'h0000_0020);
        checks++; if (validOut !== 1'b1 || PCOut !== 32'h8 || instrOut !== 32'h0000_0020) begin errors++; $display("FAIL stall_return: got valid=%0b pc=%h instr=%h want 1/8/00000020", validOut, PCOut, instrOut); end
        apply(1, 1, 0, 32'h0, 1, 32'h0);
        checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next: got %h want c", bus.imem_addr); end
    endtask

    task automatic test_hold();
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h0);
        apply(0, 1, 0, 32'h0, 1, 32'h8C41_0004);
        checks++; if (validOut !== 1'b1 || instrOut !== 32'h8C41_0004) begin errors++; $display("FAIL hold_capture: got valid=%0b instr=%h want 1/8c410004", validOut, instrOut); end
        for (int k = 0; k < 2; k++) begin
            apply((k == 1) ? 1'b1 : 1'b0, (k == 1) ? 1'b0 : 1'b1, 0, 32'h0, 1, 32'hDEAD_BEEF);
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %0b want 0", k, bus.imem_req); end
            checks++; if (validOut !== 1'b1 || instrOut !== 32'h8C41_0004 || PCOut !== 32'h0) begin errors++; $display("FAIL hold_instr[%0d]: got valid=%0b instr=%h pc=%h want 1/8c410004/0", k, validOut, instrOut, PCOut); end
        end
        apply(1, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
        checks++; if (validOut !== 1'b1 || instrOut !== 32'h8C41_0004) begin errors++; $display("FAIL hold_release: got valid=%0b instr=%h want 1/8c410004", validOut, instrOut); end
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL hold_resume: got req=%0b addr=%h want 1/4", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h0);
        apply(0, 1, 0, 32'h0, 1, 32'h1000_FFFF);
        apply(1, 1, 1, 32'h0000_0103, 0, 32'h0);
        checks++; if (validOut !== 1'b0 || instrOut !== 32'h0 || BranchOut !== 1'b0) begin errors++; $display("FAIL redir_hold_kill: got valid=%0b instr=%h br=%0b want 0/0/0", validOut, instrOut, BranchOut); end
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_hold_addr: got req=%0b addr=%h want 1/100", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        apply(1, 1, 1, 32'h0000_0040, 0, 32'h0);
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL redir_wait_hold_addr: got %h want 0", bus.imem_addr); end
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        checks++; if (validOut !== 1'b0 || instrOut !== 32'h0) begin errors++; $display("FAIL redir_wait_discard: got valid=%0b instr=%h want 0/0", validOut, instrOut); end
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_wait_addr: got req=%0b addr=%h want 1/40", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_branch_wrap();
        do_reset();
        apply(1, 1, 1, 32'hFFFF_FFFE, 0, 32'h0);
        apply(1, 1, 0, 32'h0, 1, 32'h1000_FFFF);
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || PCPlus4Out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got addr=%h pc4=%h want fffffffc/0", bus.imem_addr, PCPlus4Out); end
        checks++; if (BranchOut !== 1'b1) begin errors++; $display("FAIL branch_beq: got %0b want 1", BranchOut); end
        apply(1, 1, 0, 32'h0, 1, 32'h03E0_0008);
        checks++; if (PCOut !== 32'h0 || BranchOut !== 1'b1) begin errors++; $display("FAIL branch_jr: got pc=%h br=%0b want 0/1", PCOut, BranchOut); end
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        checks++; if (PCOut !== 32'h4 || BranchOut !== 1'b0) begin errors++; $display("FAIL branch_addi: got pc=%h br=%0b want 4/0", PCOut, BranchOut); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h0);
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        apply(1, 1, 0, 32'h0, 0, 32'h0);
        reset = 0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || PCOut !== 32'h0) begin errors++; $display("FAIL async_reset: got req=%0b pc=%h want 0/0", bus.imem_req, PCOut); end
        do_reset();
        apply(1, 1, 0, 32'h0, 1, 32'h1000_FFFF);
        checks++; if (validOut !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL late_ihit: got valid=%0b req=%0b want 0/0", validOut, bus.imem_req); end
        apply(1, 1, 0, 32'h0, 1, 32'h2001_0005);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_req: got req=%0b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_random();
        logic [31:0] ctrl_words [4];
        logic [31:0] rd;
        ctrl_words = '{32'h1000_FFFF, 32'h03E0_0008, 32'h0800_0010, 32'h0320_F809};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rd = ($urandom_range(0, 2) == 0) ? ctrl_words[$urandom_range(0, 3)] : $urandom();
            apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) != 0), ($urandom_range(0, 9) == 0),
                  $urandom(), ($urandom_range(0, 9) < 7), rd);
            checks++; if (bus.imem_req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d]: got %0b want %0b", n, bus.imem_req, exp_req); end
            checks++; if (exp_req && bus.imem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, bus.imem_addr, exp_addr); end
            checks++; if (validOut !== exp_valid || instrOut !== exp_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got valid=%0b instr=%h want %0b/%h", n, validOut, instrOut, exp_valid, exp_instr); end
            checks++; if (PCOut !== exp_pc || PCPlus4Out !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h/%h", n, PCOut, PCPlus4Out, exp_pc, exp_pc + 32'd4); end
            checks++; if (BranchOut !== exp_branch) begin errors++; $display("FAIL rnd_branch[%0d]: got %0b want %0b", n, BranchOut, exp_branch); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.Ihit = 0;
        bus.imem_rdata = 32'h0;
        model_reset();
        test_reset();
        test_stream();
        test_ihit_stall();
        test_hold();
        test_redirect_hold();
        test_redirect_wait();
        test_branch_wrap();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
